// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one synchronous FIFO write port among NUM_REQ
// producers, granting bursts of up to BURST_MAX words and honouring fifo_full.
module fifo_write_arbiter #(
    parameter  int NUM_REQ    = 4,
    parameter  int DATA_WIDTH = 32,
    parameter  int BURST_MAX  = 4,
    localparam int OW         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int CW         = $clog2(BURST_MAX + 1)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            ack,
    output logic [NUM_REQ-1:0]            grant,
    output logic [OW-1:0]                 owner,
    output logic                          busy,
    input  logic                          fifo_full,
    output logic                          fifo_cs,
    output logic                          fifo_wr_ena,
    output logic [DATA_WIDTH-1:0]         fifo_data_in
);

    typedef enum logic {IDLE, BURST} state_t;

    state_t               state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [OW-1:0]        owner_q, owner_d;
    logic [CW-1:0]        beat_q,  beat_d;

    logic [DATA_WIDTH-1:0] words [NUM_REQ];
    logic                  win_found;
    logic [OW-1:0]         win_idx;
    logic [OW-1:0]         cand;
    logic                  accept;
    logic                  last_beat;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_split
        assign words[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
    end

    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        owner_d   = owner_q;
        beat_d    = beat_q;
        win_found = 1'b0;
        win_idx   = owner_q;
        cand      = owner_q;

        // Scan owner+1 ... owner (wrapping); the current owner is tried last.
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = OW'((int'(owner_q) + 1 + k) % NUM_REQ);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end

        accept    = (state_q == BURST) && req[owner_q] && !fifo_full && !rst;
        last_beat = (beat_q == CW'(BURST_MAX - 1));

        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d = BURST;
                    grant_d = NUM_REQ'(1) << win_idx;
                    owner_d = win_idx;
                    beat_d  = '0;
                end
            end
            BURST: begin
                if (!req[owner_q] || (accept && last_beat)) begin
                    beat_d = '0;
                    if (win_found) begin
                        grant_d = NUM_REQ'(1) << win_idx;
                        owner_d = win_idx;
                    end else begin
                        state_d = IDLE;
                        grant_d = '0;
                    end
                end else if (accept) begin
                    beat_d = beat_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        fifo_wr_ena  = accept;
        fifo_cs      = accept;
        fifo_data_in = words[owner_q];
        ack          = accept ? (NUM_REQ'(1) << owner_q) : '0;
    end

    // NOTE: state registers use non-blocking assignments so all update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            owner_q <= OW'(NUM_REQ - 1);
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            owner_q <= owner_d;
            beat_q  <= beat_d;
        end
    end

    assign grant = grant_q;
    assign owner = owner_q;
    assign busy  = (state_q == BURST);

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed self-checking bench for fifo_write_arbiter (4 requesters, bursts of 4)
// with a behavioural 8-deep FIFO and random-rate reader for the integration run.
module tb_fifo_write_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int BM = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req;
    logic [N*DW-1:0] req_data;
    logic            fifo_full;
    logic [N-1:0]    ack;
    logic [N-1:0]    grant;
    logic [1:0]      owner;
    logic            busy;
    logic            fifo_cs;
    logic            fifo_wr_ena;
    logic [DW-1:0]   fifo_data_in;

    int n_pass  = 0;
    int n_total = 0;

    fifo_write_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .BURST_MAX(BM)) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .req_data     (req_data),
        .ack          (ack),
        .grant        (grant),
        .owner        (owner),
        .busy         (busy),
        .fifo_full    (fifo_full),
        .fifo_cs      (fifo_cs),
        .fifo_wr_ena  (fifo_wr_ena),
        .fifo_data_in (fifo_data_in)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] word_of(input int i);
        return req_data[i*DW +: DW];
    endfunction

    task automatic set_words(input logic [7:0] base);
        for (int i = 0; i < N; i++) req_data[i*DW +: DW] = {base, 8'(i), 16'h0000};
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0; fifo_full = 1'b0;
        step(); step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 4'b1111; fifo_full = 1'b0; set_words(8'h01);
        step();
        #2;
        n_total++;
        if ({ack, fifo_wr_ena, fifo_cs} !== 6'b0)
            $display("FAIL reset_comb: ack=%b wr=%b cs=%b, expected all 0", ack, fifo_wr_ena, fifo_cs);
        else n_pass++;
        step();
        n_total++;
        if ({grant, owner, busy} !== {4'b0000, 2'd3, 1'b0})
            $display("FAIL reset_regs: grant=%b owner=%0d busy=%b, expected 0000/3/0", grant, owner, busy);
        else n_pass++;
        rst = 1'b0; req = '0;
        step();
    endtask

    task automatic test_single();
        do_reset();
        set_words(8'h11);
        req = 4'b0001;
        step();
        // Two back-to-back bursts: requester 0 is re-granted with no bubble.
        for (int c = 0; c < 2*BM; c++) begin
            req_data[DW-1:0] = 32'hA000_0000 | 32'(c);
            #2;
            n_total++;
            if ({grant, ack, fifo_wr_ena, fifo_cs} !== {4'b0001, 4'b0001, 1'b1, 1'b1} ||
                fifo_data_in !== (32'hA000_0000 | 32'(c)))
                $display("FAIL single_beat%0d: grant=%b ack=%b wr=%b cs=%b data=%h, expected 0001/0001/1/1 data=%h",
                         c, grant, ack, fifo_wr_ena, fifo_cs, fifo_data_in, 32'hA000_0000 | 32'(c));
            else n_pass++;
            step();
        end
        req = '0;
        #2;
        n_total++;
        if ({ack, fifo_wr_ena} !== 5'b0)
            $display("FAIL single_drop: ack=%b wr=%b, expected 0000/0", ack, fifo_wr_ena);
        else n_pass++;
        step();
        n_total++;
        if ({grant, owner, busy} !== {4'b0000, 2'd0, 1'b0})
            $display("FAIL single_idle: grant=%b owner=%0d busy=%b, expected 0000/0/0", grant, owner, busy);
        else n_pass++;
    endtask

    task automatic test_round_robin();
        int exp_o;
        do_reset();
        for (int i = 0; i < N; i++) req_data[i*DW +: DW] = 32'hC0DE_0000 + 32'(i);
        req = 4'b1111;
        step();
        for (int c = 0; c < 5*BM; c++) begin
            exp_o = (c / BM) % N;
            #2;
            n_total++;
            if ({grant, ack, owner, fifo_wr_ena} !== {4'(1 << exp_o), 4'(1 << exp_o), 2'(exp_o), 1'b1} ||
                fifo_data_in !== 32'hC0DE_0000 + 32'(exp_o))
                $display("FAIL rr_cycle%0d: grant=%b ack=%b owner=%0d wr=%b data=%h, expected owner %0d data=%h",
                         c, grant, ack, owner, fifo_wr_ena, fifo_data_in, exp_o, 32'hC0DE_0000 + 32'(exp_o));
            else n_pass++;
            step();
        end
        req = '0;
        step(); step();
    endtask

    task automatic test_drop();
        do_reset();
        set_words(8'h22);
        req = 4'b0100;
        step();
        req = 4'b0110;
        for (int c = 0; c < 2; c++) begin
            #2;
            n_total++;
            if ({grant, ack} !== {4'b0100, 4'b0100} || fifo_data_in !== word_of(2))
                $display("FAIL drop_word%0d: grant=%b ack=%b data=%h, expected 0100/0100 data=%h",
                         c, grant, ack, fifo_data_in, word_of(2));
            else n_pass++;
            step();
        end
        req = 4'b0010;
        #2;
        n_total++;
        if ({ack, fifo_wr_ena} !== 5'b0)
            $display("FAIL drop_nowrite: ack=%b wr=%b, expected 0000/0", ack, fifo_wr_ena);
        else n_pass++;
        step();
        #1;
        n_total++;
        if ({grant, owner, ack} !== {4'b0010, 2'd1, 4'b0010})
            $display("FAIL drop_handoff: grant=%b owner=%0d ack=%b, expected 0010/1/0010", grant, owner, ack);
        else n_pass++;
        req = '0;
        step(); step();
    endtask

    task automatic test_stall();
        int words;
        logic stall;
        words = 0;
        do_reset();
        set_words(8'h33);
        req = 4'b0011;
        step();
        for (int c = 0; c < 9; c++) begin
            stall = (c >= 2 && c < 7);
            fifo_full = stall;
            #2;
            words += int'(ack[0]);
            n_total++;
            if (stall ? ({ack, fifo_wr_ena, grant} !== {4'b0000, 1'b0, 4'b0001})
                      : ({ack, fifo_wr_ena, grant} !== {4'b0001, 1'b1, 4'b0001}))
                $display("FAIL stall_cycle%0d: ack=%b wr=%b grant=%b, expected stall=%b grant 0001",
                         c, ack, fifo_wr_ena, grant, stall);
            else n_pass++;
            step();
        end
        fifo_full = 1'b0;
        #1;
        n_total++;
        if (grant !== 4'b0010 || words != BM)
            $display("FAIL stall_complete: grant=%b words=%0d, expected 0010 and %0d words", grant, words, BM);
        else n_pass++;
        req = '0;
        step(); step();
    endtask

    task automatic test_mid_reset();
        do_reset();
        set_words(8'h44);
        req = 4'b0010;
        step();
        for (int c = 0; c < 2; c++) begin
            #2;
            n_total++;
            if ({grant, ack} !== {4'b0010, 4'b0010})
                $display("FAIL mrst_beat%0d: grant=%b ack=%b, expected 0010/0010", c, grant, ack);
            else n_pass++;
            step();
        end
        rst = 1'b1;
        #2;
        n_total++;
        if ({ack, fifo_wr_ena, fifo_cs} !== 6'b0)
            $display("FAIL mrst_nowrite: ack=%b wr=%b cs=%b, expected all 0", ack, fifo_wr_ena, fifo_cs);
        else n_pass++;
        step();
        rst = 1'b0;
        req = 4'b1111;
        #1;
        n_total++;
        if ({grant, busy, owner} !== {4'b0000, 1'b0, 2'd3})
            $display("FAIL mrst_state: grant=%b busy=%b owner=%0d, expected 0000/0/3", grant, busy, owner);
        else n_pass++;
        step();
        n_total++;
        if ({grant, busy} !== {4'b0001, 1'b1})
            $display("FAIL mrst_first: grant=%b busy=%b, expected 0001/1", grant, busy);
        else n_pass++;
        req = '0;
        step(); step();
    endtask

    task automatic test_integration();
        logic [DW-1:0] fifo_q[$];
        int            sent [N];
        int            rcv  [N];
        int            received;
        int            r;
        int            errs;
        logic          pop;
        logic          wr;
        logic [DW-1:0] d;
        logic [DW-1:0] pd;
        logic [N-1:0]  a;
        received = 0;
        errs     = 0;
        for (int i = 0; i < N; i++) begin sent[i] = 0; rcv[i] = 0; end
        do_reset();
        for (int cyc = 0; cyc < 4000 && received < 4*16; cyc++) begin
            for (int i = 0; i < N; i++) begin
                req[i] = (sent[i] < 16);
                req_data[i*DW +: DW] = {8'(i), 8'h5A, 16'(sent[i])};
            end
            fifo_full = (fifo_q.size() >= 8);
            pop = (fifo_q.size() > 0) && ($urandom_range(0, 2) == 0);
            #2;
            wr = fifo_wr_ena; d = fifo_data_in; a = ack;
            r = -1;
            for (int i = 0; i < N; i++) if (a[i]) r = i;
            if (wr) begin
                n_total++;
                if (fifo_q.size() >= 8 || r < 0 || !$onehot(a) || d !== word_of(r)) begin
                    $display("FAIL integ_write: size=%0d ack=%b data=%h, expected room, one-hot ack and matching word",
                             fifo_q.size(), a, d);
                    errs++;
                end else n_pass++;
            end else if (a !== '0) begin
                n_total++;
                $display("FAIL integ_ack: ack=%b with wr_ena=0, expected 0000", a);
            end
            @(posedge clk);
            if (pop) begin
                pd = fifo_q.pop_front();
                r  = int'(pd[31:24]);
                n_total++;
                if (r >= N || pd[15:0] !== 16'(rcv[r]))
                    $display("FAIL integ_order: got word %h, expected seq %0d for requester %0d",
                             pd, (r < N) ? rcv[r] : -1, r);
                else n_pass++;
                if (r < N) rcv[r]++;
                received++;
            end
            if (wr && errs == 0 && r >= 0) begin
                fifo_q.push_back(d);
                sent[int'(d[31:24])]++;
            end
            #1;
        end
        n_total++;
        if (received != 4*16)
            $display("FAIL integ_total: received=%0d, expected 64", received);
        else n_pass++;
        req = '0;
        fifo_full = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req = '0; fifo_full = 1'b0; req_data = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_drop();
        test_stall();
        test_mid_reset();
        test_integration();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fifo_write_arbiter.md
Name: fifo_write_arbiter

Overview:
- Round-robin write-side arbiter that shares one synchronous FIFO among NUM_REQ producers.
- Grants one requester at a time for a burst of up to BURST_MAX words. Drives the FIFO write port (cs, wr_ena, data_in) and honours the FIFO's full flag.
- Sits between the producer blocks and the FIFO write port. The FIFO's read side is untouched.

Parameters:
- NUM_REQ, 4, number of requesters (>=2).
- DATA_WIDTH, 32, word width; must match the FIFO data_width.
- BURST_MAX, 4, maximum words accepted per grant before re-arbitration (>=1).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- req  input  NUM_REQ  per-requester "word available"; req[i] may drop at any cycle.
- req_data  input  NUM_REQ*DATA_WIDTH  packed words; requester i uses bits [i*DATA_WIDTH +: DATA_WIDTH], valid whenever req[i]=1.
- ack  output  NUM_REQ  one-hot pulse; ack[i]=1 means requester i's word is written at this clock edge.
- grant  output  NUM_REQ  registered one-hot current owner; all-zero when idle.
- owner  output  max(1,$clog2(NUM_REQ))  registered index of current owner; holds last owner when idle.
- busy  output  1  registered; 1 while in BURST state.
- fifo_full  input  1  FIFO full flag.
- fifo_cs  output  1  FIFO chip select; equals fifo_wr_ena.
- fifo_wr_ena  output  1  FIFO write enable.
- fifo_data_in  output  DATA_WIDTH  FIFO write data.

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE, grant=0, owner=NUM_REQ-1 (so requester 0 has first priority), beat counter=0, busy=0.
  - Combinational outputs ack, fifo_wr_ena, fifo_cs are 0 during reset.
  - Reset mid-burst abandons the burst. A word presented in the reset cycle is not written.
- States: IDLE, BURST.
- Priority search: scan owner+1, owner+2, ..., wrapping modulo NUM_REQ, ending at owner itself. The first index with req set wins.
- IDLE:
  - No writes.
  - If any req is high, load grant/owner with the winner, clear the beat counter and go to BURST.
  - Arbitration latency: 1 cycle from req rising to grant.
- BURST:
  - accept = req[owner] & ~fifo_full & ~rst (combinational).
  - fifo_wr_ena = fifo_cs = accept.
  - fifo_data_in = req_data slice of owner, driven even when not accepting.
  - ack = accept ? onehot(owner) : 0.
  - On accept, beat counter +1. Counter width is $clog2(BURST_MAX+1).
- Stall: if req[owner]=1 and fifo_full=1, there is no write, no count, and the grant is held indefinitely (no timeout).
- Burst end, evaluated in the BURST cycle:
  - (a) req[owner]=0, or
  - (b) accept is true and this is the BURST_MAX-th beat.
- On burst end:
  - Run the priority search on the current req. The ending owner is lowest priority; it is re-granted only if no other requester is asking.
  - If there is a winner, load it and stay in BURST with the counter cleared. The new owner can write in the very next cycle: zero-bubble handoff on (b), one idle write cycle on (a).
  - If there is no winner, go to IDLE with grant=0; owner keeps its value.
- The FIFO's full flag is pointer-derived. A write accepted at edge N is reflected in fifo_full after edge N; the arbiter needs no look-ahead.
- At most one ack bit and one FIFO write per cycle. Words from one requester reach the FIFO in presentation order.
- Simultaneous req rise of several requesters: the winner follows the priority search; the others wait.
- Fairness: with all requesters continuously active, each gets exactly BURST_MAX words per round, in order owner+1...

Test Plan:
- Reset then req=4'b0001 held, FIFO empty, BURST_MAX=4:
  - grant=0001 one cycle after req.
  - ack[0] on 4 consecutive cycles, fifo_wr_ena=1 for 4 cycles.
  - Then req0 is re-granted with zero bubble, since it is the only requester.
- req=4'b1111 continuous, FIFO never full:
  - Owner sequence 0,1,2,3,0, with 4 words each.
  - fifo_data_in matches each owner's slice on every write.
  - No idle cycle between bursts.
- Owner 2 drops req after 2 words while req1 is high:
  - That cycle has no write.
  - Next cycle grant=0010 (owner 1, the wrap-around search from 3).
- fifo_full=1 asserted mid-burst for 5 cycles with req held:
  - ack=0 and fifo_wr_ena=0 for 5 cycles, grant unchanged.
  - Burst resumes and completes the remaining beats.
  - Total words = BURST_MAX.
- rst=1 for one cycle mid-burst (owner 1, beat 2):
  - Next cycle grant=0, busy=0, no write during the reset cycle.
  - With req=1111 afterwards, requester 0 is granted first.
- Full integration: 4 requesters each send 16 tagged words into an 8-deep FIFO. A reader drains at a random rate.
  - All 64 words arrive, per-requester order is preserved.
  - The FIFO never overflows.
